// File: rtl/mem_reader.sv
// Burst memory reader: streams count words starting at start_adrs from a
// one-cycle-latency memory to a valid/ready consumer through a 2-entry FIFO.
module mem_reader #(
  parameter int ADRS_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADRS_W-1:0] start_adrs,
  input  logic [ADRS_W-1:0] count,
  output logic              r_enable,
  output logic [ADRS_W-1:0] r_adrs,
  input  logic [DATA_W-1:0] r_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADRS_W-1:0] ptr_q, ptr_d;
  logic [ADRS_W-1:0] issue_q, issue_d;
  logic [ADRS_W-1:0] accept_q, accept_d;
  logic              inflight_q, inflight_d;
  logic [DATA_W-1:0] slot0_q, slot0_d;
  logic [DATA_W-1:0] slot1_q, slot1_d;
  logic              wr_idx_q, wr_idx_d;
  logic              rd_idx_q, rd_idx_d;
  logic [1:0]        occ_q, occ_d;

  logic              pop;
  logic              push;
  logic [2:0]        level;
  logic [DATA_W-1:0] head;

  assign out_valid = (occ_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign push      = inflight_q;
  assign head      = rd_idx_q ? slot1_q : slot0_q;
  assign out_data  = out_valid ? head : '0;
  assign r_adrs    = ptr_q;
  assign busy      = (state_q == READ) || (state_q == DRAIN);
  assign done      = (state_q == DONE);

  // Words already buffered or on their way back, after this cycle's pop;
  // issuing only below 2 keeps the 2-entry FIFO from ever overflowing.
  assign level    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign r_enable = (state_q == READ) && (issue_q != '0) && (level < 3'd2);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    issue_d    = issue_q;
    accept_d   = accept_q;
    inflight_d = r_enable;
    slot0_d    = slot0_q;
    slot1_d    = slot1_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    occ_d      = occ_q + {1'b0, push} - {1'b0, pop};

    if (push) begin
      if (wr_idx_q) slot1_d = r_data;
      else          slot0_d = r_data;
      wr_idx_d = ~wr_idx_q;
    end
    if (pop) begin
      rd_idx_d = ~rd_idx_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d    = start_adrs;
          issue_d  = count;
          accept_d = count;
          state_d  = (count != '0) ? READ : DONE;
        end
      end
      READ: begin
        accept_d = accept_q - ADRS_W'(pop);
        if (r_enable) begin
          ptr_d   = ptr_q + ADRS_W'(1);
          issue_d = issue_q - ADRS_W'(1);
          if (issue_q == ADRS_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        accept_d = accept_q - ADRS_W'(pop);
        if (accept_d == '0) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      issue_q    <= '0;
      accept_q   <= '0;
      inflight_q <= 1'b0;
      slot0_q    <= '0;
      slot1_q    <= '0;
      wr_idx_q   <= 1'b0;
      rd_idx_q   <= 1'b0;
      occ_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      issue_q    <= issue_d;
      accept_q   <= accept_d;
      inflight_q <= inflight_d;
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      occ_q      <= occ_d;
    end
  end

endmodule

// File: tb/tb_mem_reader.sv
// Scoreboard bench for mem_reader: stimulus pushes expected addresses/words,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_mem_reader;

  localparam int ADRS_W = 11;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADRS_W-1:0] start_adrs;
  logic [ADRS_W-1:0] count;
  logic              r_enable;
  logic [ADRS_W-1:0] r_adrs;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  int compared = 0;
  int errors   = 0;
  int done_count = 0;
  int reads_issued = 0;
  bit saw_ren, saw_ov, saw_busy;
  bit held_valid = 1'b0;
  logic [DATA_W-1:0] held_data;

  logic [DATA_W-1:0] exp_data_q[$];
  logic [ADRS_W-1:0] exp_adrs_q[$];

  mem_reader #(.ADRS_W(ADRS_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .start(start), .start_adrs(start_adrs),
    .count(count), .r_enable(r_enable), .r_adrs(r_adrs), .r_data(r_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Memory contents: three fixed words at the bottom, a tagged address elsewhere.
  function automatic logic [DATA_W-1:0] mem_word(input logic [ADRS_W-1:0] a);
    case (a)
      11'd0:   return 32'h0000000d;
      11'd1:   return 32'h0000000f;
      11'd2:   return 32'h000000c3;
      default: return 32'hC0DE_0000 | {21'b0, a};
    endcase
  endfunction

  // One-cycle-latency synchronous memory, unaffected by the DUT reset.
  always @(posedge clk) begin
    if (r_enable) r_data <= mem_word(r_adrs);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives a one-cycle start pulse beginning now; returns at the following negedge.
  task automatic applyStimulus(input logic [ADRS_W-1:0] adrs, input logic [ADRS_W-1:0] cnt);
    start      = 1'b1;
    start_adrs = adrs;
    count      = cnt;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic expectBurst(input logic [ADRS_W-1:0] adrs, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      exp_adrs_q.push_back(adrs + ADRS_W'(i));
      exp_data_q.push_back(mem_word(adrs + ADRS_W'(i)));
    end
  endtask

  task automatic waitDone(input string name, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput({name, "_done_seen"}, {31'b0, found}, 32'd1);
    @(negedge clk);
    checkOutput({name, "_leftover"}, exp_data_q.size(), 32'd0);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_r_enable"}, {31'b0, r_enable}, 32'd0);
    checkOutput({name, "_r_adrs"}, {21'b0, r_adrs}, 32'd0);
    checkOutput({name, "_out_data"}, out_data, 32'd0);
    checkOutput({name, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    checkOutput({name, "_busy"}, {31'b0, busy}, 32'd0);
    checkOutput({name, "_done"}, {31'b0, done}, 32'd0);
  endtask

  // Monitor: read addresses, delivered words, held data under back-pressure.
  always @(negedge clk) begin
    if (reset) begin
      held_valid = 1'b0;
    end else begin
      if (r_enable) begin
        reads_issued++;
        saw_ren = 1'b1;
        if (exp_adrs_q.size() == 0) checkOutput("unexpected_read", {21'b0, r_adrs}, 32'hFFFF_FFFF);
        else checkOutput("r_adrs", {21'b0, r_adrs}, {21'b0, exp_adrs_q.pop_front()});
      end
      if (out_valid) saw_ov = 1'b1;
      if (busy) saw_busy = 1'b1;
      if (done) done_count++;
      if (out_valid && held_valid) checkOutput("held_data", out_data, held_data);
      if (out_valid && out_ready) begin
        held_valid = 1'b0;
        if (exp_data_q.size() == 0) checkOutput("unexpected_word", out_data, 32'hFFFF_FFFF);
        else checkOutput("out_data", out_data, exp_data_q.pop_front());
      end else if (out_valid) begin
        held_valid = 1'b1;
        held_data  = out_data;
      end else begin
        held_valid = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0;
    reset = 1'b1; start = 1'b0; start_adrs = '0; count = '0; out_ready = 1'b1;
    r_data = '0;
    #12;
    checkAllZero("reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Three-word burst from address 0 with literal expected words and timing.
    $display("[TB] burst of 3 from 0");
    exp_adrs_q.push_back(11'h000); exp_adrs_q.push_back(11'h001); exp_adrs_q.push_back(11'h002);
    exp_data_q.push_back(32'h0000000d); exp_data_q.push_back(32'h0000000f);
    exp_data_q.push_back(32'h000000c3);
    applyStimulus(11'h000, 11'd3);
    checkOutput("t1_ren_first", {31'b0, r_enable}, 32'd1);
    checkOutput("t1_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    checkOutput("t1_valid_e1", {31'b0, out_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("t1_valid_stream", {31'b0, out_valid}, 32'd1);
    end
    @(negedge clk);
    checkOutput("t1_done", {31'b0, done}, 32'd1);
    checkOutput("t1_busy_in_done", {31'b0, busy}, 32'd0);
    @(negedge clk);
    checkOutput("t1_done_one_cycle", {31'b0, done}, 32'd0);
    checkOutput("t1_leftover", exp_data_q.size(), 32'd0);

    // Address wrap at the top of memory.
    $display("[TB] wrap burst from 0x7FE");
    exp_adrs_q.push_back(11'h7FE); exp_adrs_q.push_back(11'h7FF); exp_adrs_q.push_back(11'h000);
    exp_data_q.push_back(32'hC0DE07FE); exp_data_q.push_back(32'hC0DE07FF);
    exp_data_q.push_back(32'h0000000d);
    applyStimulus(11'h7FE, 11'd3);
    waitDone("t2", 50);

    // Back-pressure: consumer stalls for 5 cycles after the first word.
    $display("[TB] stalled burst of 4");
    out_ready = 1'b0;
    expectBurst(11'h010, 4);
    reads_issued = 0;
    applyStimulus(11'h010, 11'd4);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    checkOutput("t3_valid_seen", {31'b0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("t3_stall_word0", out_data, 32'hC0DE0010);
      @(negedge clk);
    end
    checkOutput("t3_max_two_reads", {31'b0, reads_issued <= 2}, 32'd1);
    out_ready = 1'b1;
    waitDone("t3", 50);

    // Empty burst.
    $display("[TB] empty burst");
    saw_ren = 1'b0; saw_ov = 1'b0; saw_busy = 1'b0;
    applyStimulus(11'h055, 11'd0);
    checkOutput("t4_done_next", {31'b0, done}, 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("t4_no_ren", {31'b0, saw_ren}, 32'd0);
    checkOutput("t4_no_valid", {31'b0, saw_ov}, 32'd0);
    checkOutput("t4_no_busy", {31'b0, saw_busy}, 32'd0);

    // Reset mid-burst, then an immediate restart.
    $display("[TB] reset mid-burst");
    expectBurst(11'h100, 8);
    applyStimulus(11'h100, 11'd8);
    repeat (3) @(negedge clk);
    d0 = done_count;
    #2 reset = 1'b1;
    #1 checkAllZero("t5_midreset");
    exp_data_q.delete();
    exp_adrs_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    expectBurst(11'h200, 2);
    applyStimulus(11'h200, 11'd2);
    checkOutput("t5_restart_ren", {31'b0, r_enable}, 32'd1);
    waitDone("t5", 50);
    checkOutput("t5_one_done", done_count - d0, 32'd1);

    // Start pulsed again while busy must be ignored.
    $display("[TB] start during busy");
    d0 = done_count;
    expectBurst(11'h300, 4);
    applyStimulus(11'h300, 11'd4);
    @(negedge clk);
    start = 1'b1; start_adrs = 11'h400; count = 11'd7;
    @(negedge clk);
    start = 1'b0;
    waitDone("t6", 50);
    repeat (10) @(negedge clk);
    checkOutput("t6_one_done", done_count - d0, 32'd1);
    checkOutput("t6_no_extra_reads", exp_adrs_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
    $finish;
  end

endmodule

// File: doc/mem_reader.md
MEM_READER -- requirements
Module: mem_reader

Interface
REQ-001 Parameter ADRS_W, default 11, instruction/data memory address width.
REQ-002 Parameter DATA_W, default 32, memory word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-005 start  input  1  one-cycle request to begin a readback burst; sampled only in IDLE.
REQ-006 start_adrs  input  ADRS_W  first memory address of the burst, captured with start.
REQ-007 count  input  ADRS_W  number of words to read, captured with start; 0 = empty burst.
REQ-008 r_enable  output  1  memory read strobe, one word per asserted cycle.
REQ-009 r_adrs  output  ADRS_W  read address, valid while r_enable is high.
REQ-010 r_data  input  DATA_W  memory read data, valid exactly one cycle after its r_enable cycle.
REQ-011 out_data  output  DATA_W  streamed word to the consumer.
REQ-012 out_valid  output  1  out_data holds a valid word.
REQ-013 out_ready  input  1  consumer accepts; transfer occurs on a cycle with out_valid and out_ready both high.
REQ-014 busy  output  1  high from start capture until done; CPU enable is gated with ~busy externally.
REQ-015 done  output  1  one-cycle pulse when the burst completes.

Function
REQ-016 The FSM SHALL have states IDLE, READ, DRAIN, DONE.
REQ-017 IDLE: start=1 with count!=0 -> READ, latching start_adrs into the read pointer and count into the issue and accept counters.
REQ-018 IDLE: start=1 with count=0 -> DONE directly; no r_enable, no out_valid.
REQ-019 READ: r_enable SHALL assert only when FIFO occupancy + in-flight reads - (this cycle's pop) < 2.
REQ-020 Each issued read SHALL increment r_adrs by 1, modulo 2^ADRS_W (0x7FF wraps to 0x000), and decrement the issue counter.
REQ-021 READ -> DRAIN when the final read is issued; DRAIN -> DONE when the accept counter reaches 0.
REQ-022 DONE SHALL last exactly one cycle with done=1, then return to IDLE; busy=0 in DONE.
REQ-023 r_data SHALL be written into a 2-entry FIFO on the cycle after its r_enable; the FIFO never overflows by REQ-019.
REQ-024 out_data/out_valid SHALL come from the FIFO head; out_data is held stable while out_valid=1 and out_ready=0.
REQ-025 Latency: start sampled at edge E0 -> r_enable in cycle E0..E1 -> data captured at E2 -> out_valid high after E2.
REQ-026 With out_ready held high, throughput SHALL be one word per cycle with no bubbles after the first word.
REQ-027 A simultaneous push and pop on a full or empty-plus-one FIFO SHALL keep occupancy unchanged and preserve order.
REQ-028 start asserted while busy SHALL be ignored, with no effect on the current burst.
REQ-029 Words SHALL be delivered in ascending-address order; each address is read exactly once per burst.

Reset
REQ-030 While reset=1, all outputs SHALL be 0: r_enable, r_adrs, out_data, out_valid, busy, done; FSM=IDLE; FIFO empty; counters 0.
REQ-031 Reset asserted mid-burst SHALL abort the burst; read data returning after release SHALL be discarded; no done pulse.
REQ-032 After reset deassertion, the first start SHALL be honoured on the first rising edge.

Verification
REQ-033 mem[0..2]=0x0000000d,0x0000000f,0x000000c3; start_adrs=0, count=3, out_ready=1 -> out_data 0x0d,0x0f,0xc3 on 3 consecutive cycles, first out_valid 2 edges after start, then done pulse.
REQ-034 start_adrs=0x7FE, count=3 -> r_adrs 0x7FE,0x7FF,0x000; data delivered in that order.
REQ-035 count=4, out_ready low for 5 cycles after first out_valid -> out_data held at word 0, at most 2 reads issued, all 4 words delivered once ready rises.
REQ-036 count=0 -> done pulse the cycle after start; r_enable and out_valid never assert; busy never asserts.
REQ-037 reset pulsed mid-way through count=8 -> all outputs 0 immediately; stale r_data never appears on out_valid; a new start with count=2 completes normally.
REQ-038 start pulsed again during an active count=4 burst -> exactly 4 words delivered and one done pulse.
